// File: rtl/dmem_arbiter.sv
// Shared 8-bit data memory with a 3-state req/gnt/done arbiter (CPU port 0, host port 1).
// Round-robin by default; DMEM_HOST_PRIO_EN selects fixed host priority.
module dmem_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_sel;
  logic          r_rr;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_cpu_gnt;
  logic          r_host_gnt;
  logic          r_cpu_done;
  logic          r_host_done;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          r_busy;

  // Contents survive reset; this is the power-up image.
  logic [DW-1:0] r_mem [DEPTH] = '{
    0: DW'(8'hFF),
    1: DW'(8'hFE),
    2: DW'(8'hFD),
    default: '0
  };

  logic          w_any_req;
  logic          w_host_win;
  logic          w_addr_ok;
  logic [IW-1:0] w_idx;

  assign w_any_req = cpu_req | host_req;
  assign w_addr_ok = {1'b0, r_addr} < (AW+1)'(DEPTH);
  assign w_idx     = r_addr[IW-1:0];

`ifdef DMEM_HOST_PRIO_EN
  assign w_host_win = host_req;
`else
  assign w_host_win = host_req & (~cpu_req | r_rr);
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_rr        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_gnt   <= 1'b0;
      r_host_gnt  <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_host_done <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_cpu_gnt   <= 1'b0;
      r_host_gnt  <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_host_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel      <= w_host_win;
            r_we       <= w_host_win ? host_we    : cpu_we;
            r_addr     <= w_host_win ? host_addr  : cpu_addr;
            r_wdata    <= w_host_win ? host_wdata : cpu_wdata;
            r_host_gnt <= w_host_win;
            r_cpu_gnt  <= ~w_host_win;
          end
        end
        S_ACCESS: begin
          r_err       <= ~w_addr_ok;
          r_rdata     <= (w_addr_ok && !r_we) ? r_mem[w_idx] : '0;
          r_host_done <= r_sel;
          r_cpu_done  <= ~r_sel;
        end
        S_DONE: begin
          r_err <= 1'b0;
          r_rr  <= ~r_sel;
        end
        default: ;
      endcase
    end
  end

  // Reset on the ACCESS edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_ACCESS && r_we && w_addr_ok)
      r_mem[w_idx] <= r_wdata;
  end

  assign cpu_gnt   = r_cpu_gnt;
  assign cpu_done  = r_cpu_done;
  assign host_gnt  = r_host_gnt;
  assign host_done = r_host_done;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter; follows DMEM_HOST_PRIO_EN
// for the contention test.
module tb_dmem_arbiter;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_gnt;
  logic       cpu_done;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [4:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic       host_done;
  logic [7:0] rdata;
  logic       err;
  logic       busy;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_done   (cpu_done),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_done  (host_done),
    .rdata      (rdata),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   n_tot = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t m_e;
  logic [7:0] mdl [16];
  bit   host_seen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (host_gnt || host_done) host_seen = 1'b1;
    if (cpu_done || host_done) begin
      chk("one_done", 32'(cpu_done & host_done), 0);
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("done_port", 32'(host_done), 32'(m_e.port));
        chk("rdata", 32'(rdata), 32'(m_e.data));
        chk("err", 32'(err), 32'(m_e.err));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic access(input logic port, input logic we,
                        input logic [4:0] addr, input logic [7:0] wd);
    exp_t e;
    int   n;
    bit   seen;
    e.port = port;
    if (addr < 5'd16) begin
      e.err = 1'b0;
      if (we) begin
        mdl[addr[3:0]] = wd;
        e.data = 8'h00;
      end else begin
        e.data = mdl[addr[3:0]];
      end
    end else begin
      e.err  = 1'b1;
      e.data = 8'h00;
    end
    sb.push_back(e);
    if (port) begin
      host_req = 1'b1; host_we = we;
      host_addr = addr; host_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we;
      cpu_addr = addr; cpu_wdata = wd;
    end
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      seen = port ? host_gnt : cpu_gnt;
    end
    chk("gnt_lat", n, 1);
    chk("busy_acc", 32'(busy), 1);
    // Scramble inputs: the latched request must be used.
    if (port) begin
      host_req = 1'b0;
      host_addr = 5'($urandom); host_wdata = 8'($urandom);
    end else begin
      cpu_req = 1'b0;
      cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
    end
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      seen = port ? host_done : cpu_done;
    end
    chk("done_lat", n, 1);
    @(posedge clk); #1;
    chk("busy_idle", 32'(busy), 0);
  endtask

  logic exp_ord [4];
  int   g;
  int   cyc;
  int   last;

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    mdl[0] = 8'hFF; mdl[1] = 8'hFE; mdl[2] = 8'hFD;

    do_reset();
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_cpu_done", 32'(cpu_done), 0);
    chk("rst_host_gnt", 32'(host_gnt), 0);
    chk("rst_host_done", 32'(host_done), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: CPU read of word 1, host side quiet
    host_seen = 1'b0;
    access(1'b0, 1'b0, 5'd1, 8'h00);
    chk("t1_host_quiet", 32'(host_seen), 0);

    // 2: host write then CPU read back
    access(1'b1, 1'b1, 5'd4, 8'h5A);
    access(1'b0, 1'b0, 5'd4, 8'h00);
    access(1'b0, 1'b1, 5'd9, 8'hC3);
    access(1'b1, 1'b0, 5'd9, 8'h00);
    access(1'b1, 1'b0, 5'd2, 8'h00);

    // 3/6: both ports requesting continuously from reset
    do_reset();
`ifdef DMEM_HOST_PRIO_EN
    exp_ord[0] = 1'b1; exp_ord[1] = 1'b1;
    exp_ord[2] = 1'b1; exp_ord[3] = 1'b0;
`else
    exp_ord[0] = 1'b0; exp_ord[1] = 1'b1;
    exp_ord[2] = 1'b0; exp_ord[3] = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      m_e.port = exp_ord[i]; m_e.data = mdl[0]; m_e.err = 1'b0;
      sb.push_back(m_e);
    end
    cpu_we = 1'b0; cpu_addr = 5'd0;
    host_we = 1'b0; host_addr = 5'd0;
    cpu_req = 1'b1; host_req = 1'b1;
    g = 0; cyc = 0; last = 0;
    while (g < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (cpu_gnt || host_gnt) begin
        chk("ord", 32'(host_gnt), 32'(exp_ord[g]));
        if (g > 0) chk("gap", cyc - last, 3);
        last = cyc;
        g++;
`ifdef DMEM_HOST_PRIO_EN
        if (g == 3) host_req = 1'b0;
`endif
        if (g == 4) begin
          cpu_req = 1'b0; host_req = 1'b0;
        end
      end
    end
    chk("n_gnt", g, 4);
    repeat (4) @(posedge clk);
    #1;

    // 4: out-of-range accesses, then full memory scan
    access(1'b0, 1'b0, 5'd20, 8'h00);
    access(1'b1, 1'b1, 5'd31, 8'h77);
    for (int i = 0; i < 16; i++) access(1'b0, 1'b0, 5'(i), 8'h00);

    // 5: reset on the ACCESS edge aborts the write
    host_we = 1'b1; host_addr = 5'd3; host_wdata = 8'hAA;
    host_req = 1'b1;
    @(posedge clk); #1;
    chk("ab_gnt", 32'(host_gnt), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; host_req = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(host_done), 0);
    chk("ab_gnt_low", 32'(host_gnt), 0);
    @(posedge clk); #1;
    chk("ab_busy2", 32'(busy), 0);
    access(1'b0, 1'b0, 5'd3, 8'h00);

    repeat (3) @(posedge clk);
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
